// File: rtl/data_mem_responder.sv
// data_mem_responder: memory-stage responder between the EXE/MEM and MEM/WB
// registers. It accepts a level-type read/write request and performs a word
// access to an internal array over LATENCY stall cycles. It then returns the
// load data in a one-cycle DONE state.
// Optional feature: define DATA_MEM_MISALIGN_TRAP_EN to add the misalign port.
// With the feature enabled, accesses whose byte address is not word aligned
// are suppressed.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        mem_stall,
`ifdef DATA_MEM_MISALIGN_TRAP_EN
    output logic        mem_done,
    output logic        misalign
`else
    output logic        mem_done
`endif
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(LATENCY + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          lat_write;
    logic [AW-1:0] lat_idx;
    logic [31:0]   lat_data;
    logic          lat_mis;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          req;
    logic [AW-1:0] in_idx;
    logic          in_mis;
    logic          unused_addr;

    logic          commit_fire;
    logic          commit_write;
    logic [AW-1:0] commit_idx;
    logic [31:0]   commit_data;
    logic          commit_mis;

    assign req    = mem_read | mem_write;
    assign in_idx = address[AW+1:2];
`ifdef DATA_MEM_MISALIGN_TRAP_EN
    assign in_mis = (address[1:0] != 2'b00);
`else
    assign in_mis = 1'b0;
`endif
    // Upper address bits wrap; byte-offset bits only matter with the trap enabled.
    assign unused_addr = ^{address[31:AW+2], address[1:0]};

    // Select the access to commit on the edge that enters DONE.
    // A single-cycle latency commits straight from the live inputs.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        commit_fire  = 1'b0;
        commit_write = lat_write;
        commit_idx   = lat_idx;
        commit_data  = lat_data;
        commit_mis   = lat_mis;
        if (state == S_IDLE && req && LATENCY == 1) begin
            commit_fire  = 1'b1;
            commit_write = mem_write;
            commit_idx   = in_idx;
            commit_data  = write_data;
            commit_mis   = in_mis;
        end else if (state == S_BUSY && cnt == CW'(1)) begin
            commit_fire = 1'b1;
        end
        // A reset on the committing edge aborts the access.
        if (rst) begin
            commit_fire = 1'b0;
        end
    end

    // Control FSM, request latch and registered load data.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            lat_write <= 1'b0;
            lat_idx   <= '0;
            lat_data  <= '0;
            lat_mis   <= 1'b0;
            read_data <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        lat_write <= mem_write;
                        lat_idx   <= in_idx;
                        lat_data  <= write_data;
                        lat_mis   <= in_mis;
                        cnt       <= CW'(LATENCY - 1);
                        state     <= (LATENCY > 1) ? S_BUSY : S_DONE;
                    end
                end
                S_BUSY: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
            if (commit_fire && !commit_write && !commit_mis) begin
                read_data <= mem[commit_idx];
            end
        end
    end

    // Data array write port.
    always_ff @(posedge clk) begin
        // NOTE: the array is deliberately not reset; only its write enable is gated by rst.
        if (commit_fire && commit_write && !commit_mis) begin
            mem[commit_idx] <= commit_data;
        end
    end

    assign mem_stall = !rst && ((state == S_IDLE && req) || state == S_BUSY);
    assign mem_done  = (state == S_DONE);
`ifdef DATA_MEM_MISALIGN_TRAP_EN
    assign misalign  = (state == S_DONE) && lat_mis;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder. It drives three instances with latencies
// of 2, 1 and 3. A word-array reference model in the bench supplies every
// expected read_data, stall, done and misalign value.
module tb_data_mem_responder;

    logic        clk;
    logic        rst_v        [3];
    logic        mem_read_v   [3];
    logic        mem_write_v  [3];
    logic [31:0] address_v    [3];
    logic [31:0] write_data_v [3];
    logic [31:0] read_data_v  [3];
    logic        mem_stall_v  [3];
    logic        mem_done_v   [3];
`ifdef DATA_MEM_MISALIGN_TRAP_EN
    logic        misalign_v   [3];
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    // Reference model state: word arrays and last load value per instance.
    logic [31:0] mdl_mem [3][256];
    logic [31:0] mdl_rd  [3];

    int tests  = 0;
    int failed = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_l2 (
        .clk(clk), .rst(rst_v[0]), .mem_read(mem_read_v[0]), .mem_write(mem_write_v[0]),
        .address(address_v[0]), .write_data(write_data_v[0]), .read_data(read_data_v[0]),
`ifdef DATA_MEM_MISALIGN_TRAP_EN
        .misalign(misalign_v[0]),
`endif
        .mem_stall(mem_stall_v[0]), .mem_done(mem_done_v[0]));

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst_v[1]), .mem_read(mem_read_v[1]), .mem_write(mem_write_v[1]),
        .address(address_v[1]), .write_data(write_data_v[1]), .read_data(read_data_v[1]),
`ifdef DATA_MEM_MISALIGN_TRAP_EN
        .misalign(misalign_v[1]),
`endif
        .mem_stall(mem_stall_v[1]), .mem_done(mem_done_v[1]));

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(3)) u_l3 (
        .clk(clk), .rst(rst_v[2]), .mem_read(mem_read_v[2]), .mem_write(mem_write_v[2]),
        .address(address_v[2]), .write_data(write_data_v[2]), .read_data(read_data_v[2]),
`ifdef DATA_MEM_MISALIGN_TRAP_EN
        .misalign(misalign_v[2]),
`endif
        .mem_stall(mem_stall_v[2]), .mem_done(mem_done_v[2]));

    function automatic int lat_of(input int i);
        case (i)
            0:       return 2;
            1:       return 1;
            default: return 3;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One complete access. The task starts just after a rising edge and ends
    // just after the edge that leaves DONE. The request is dropped during DONE.
    task automatic access(input int i, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] data);
        int lat;
        int idx;
        bit mis;
        lat = lat_of(i);
        idx = int'((addr >> 2) % 256);
        mis = TRAP && (addr[1:0] != 2'b00);
        mem_read_v[i]   = rd;
        mem_write_v[i]  = wr;
        address_v[i]    = addr;
        write_data_v[i] = data;
        if (!mis) begin
            if (wr)      mdl_mem[i][idx] = data;
            else if (rd) mdl_rd[i] = mdl_mem[i][idx];
        end
        for (int k = 0; k < lat; k++) begin
            @(negedge clk);
            check($sformatf("stall[%0d] L%0d cyc%0d", i, lat, k), 32'(mem_stall_v[i]), 32'd1);
            check($sformatf("done_low[%0d] L%0d cyc%0d", i, lat, k), 32'(mem_done_v[i]), 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check($sformatf("done[%0d] a=%08h", i, addr), 32'(mem_done_v[i]), 32'd1);
        check($sformatf("stall_done[%0d] a=%08h", i, addr), 32'(mem_stall_v[i]), 32'd0);
        check($sformatf("read_data[%0d] a=%08h", i, addr), read_data_v[i], mdl_rd[i]);
`ifdef DATA_MEM_MISALIGN_TRAP_EN
        check($sformatf("misalign[%0d] a=%08h", i, addr), 32'(misalign_v[i]), 32'(mis));
`endif
        mem_read_v[i]  = 1'b0;
        mem_write_v[i] = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] a;
        int          r;
        for (int i = 0; i < 3; i++) begin
            rst_v[i]        = 1'b1;
            mem_read_v[i]   = 1'b0;
            mem_write_v[i]  = 1'b0;
            address_v[i]    = 32'h0;
            write_data_v[i] = 32'h0;
            mdl_rd[i]       = 32'h0;
        end
        // A write held during reset must be dropped.
        mem_write_v[0]  = 1'b1;
        address_v[0]    = 32'h10;
        write_data_v[0] = 32'h0BAD_0BAD;
        @(posedge clk); #1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("rst_stall", 32'(mem_stall_v[0]), 32'd0);
            check("rst_done", 32'(mem_done_v[0]), 32'd0);
            check("rst_read_data", read_data_v[0], 32'h0);
            @(posedge clk); #1;
        end
        for (int i = 0; i < 3; i++) rst_v[i] = 1'b0;
        mem_write_v[0] = 1'b0;
        @(negedge clk);
        check("idle_stall", 32'(mem_stall_v[0]), 32'd0);
        check("idle_done", 32'(mem_done_v[0]), 32'd0);
        @(posedge clk); #1;

        // LATENCY=2 directed.
        access(0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
        access(0, 1'b1, 1'b0, 32'h10, 32'h0);
        access(0, 1'b0, 1'b1, 32'h40, 32'h1234_5678);
        access(0, 1'b1, 1'b0, 32'h40, 32'h0);
        // Wrap: 0x400 aliases word 0.
        access(0, 1'b0, 1'b1, 32'h400, 32'h55);
        access(0, 1'b1, 1'b0, 32'h0, 32'h0);
        // Read and write together act as a write.
        access(0, 1'b1, 1'b1, 32'h8, 32'h77);
        access(0, 1'b1, 1'b0, 32'h8, 32'h0);

        // LATENCY=1 back-to-back.
        access(1, 1'b0, 1'b1, 32'h0, 32'hA);
        access(1, 1'b0, 1'b1, 32'h4, 32'hB);
        access(1, 1'b1, 1'b0, 32'h0, 32'h0);
        access(1, 1'b1, 1'b0, 32'h4, 32'h0);

        // LATENCY=3: reset in the middle BUSY cycle aborts the write.
        access(2, 1'b0, 1'b1, 32'h20, 32'h11);
        access(2, 1'b1, 1'b0, 32'h20, 32'h0);
        mem_write_v[2]  = 1'b1;
        address_v[2]    = 32'h20;
        write_data_v[2] = 32'hFF;
        @(posedge clk); #1;
        rst_v[2]       = 1'b1;
        mem_write_v[2] = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("abort_stall", 32'(mem_stall_v[2]), 32'd0);
        check("abort_done", 32'(mem_done_v[2]), 32'd0);
        check("abort_read_data", read_data_v[2], 32'h0);
        mdl_rd[2] = 32'h0;
        @(posedge clk); #1;
        rst_v[2] = 1'b0;
        access(2, 1'b1, 1'b0, 32'h20, 32'h0);

`ifdef DATA_MEM_MISALIGN_TRAP_EN
        access(0, 1'b0, 1'b1, 32'h20, 32'hCAFE_0020);
        access(0, 1'b0, 1'b1, 32'h22, 32'h9999_9999);
        access(0, 1'b1, 1'b0, 32'h20, 32'h0);
`endif

        // Randomized phase: preload words 0..15, then mixed accesses.
        for (int i = 0; i < 3; i++) begin
            for (int w = 0; w < 16; w++) begin
                access(i, 1'b0, 1'b1, 32'(w) << 2, $urandom);
            end
            for (int n = 0; n < 24; n++) begin
                a = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2);
                if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
                r = int'($urandom_range(0, 3));
                case (r)
                    0:       access(i, 1'b0, 1'b1, a, $urandom);
                    2:       access(i, 1'b1, 1'b1, a, $urandom);
                    default: access(i, 1'b1, 1'b0, a, 32'h0);
                endcase
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
